// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared across the ALU status interface.
//   - cond_code encodings COND_EQ .. COND_NV (codes 14/15 are reserved)
//   - query FSM state enum
//   - bit positions inside the {S,Z,C,V} flag vector
package alu_pkg;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_MI = 4'd2;
    localparam logic [3:0] COND_PL = 4'd3;
    localparam logic [3:0] COND_CS = 4'd4;
    localparam logic [3:0] COND_CC = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_LT = 4'd8;
    localparam logic [3:0] COND_GE = 4'd9;
    localparam logic [3:0] COND_LE = 4'd10;
    localparam logic [3:0] COND_GT = 4'd11;
    localparam logic [3:0] COND_AL = 4'd12;
    localparam logic [3:0] COND_NV = 4'd13;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } cond_state_t;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational branch-condition evaluator.
//   flags     in  4  {S,Z,C,V}
//   cond_code in  4  condition selector
//   taken     out 1  condition result (0 for reserved codes)
//   err       out 1  cond_code is reserved (14/15)
module cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond_code,
    output logic       taken,
    output logic       err
);

    logic s, z, c, v;
    assign s = flags[FLAG_S];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        taken = 1'b0;
        err   = 1'b0;
        case (cond_code)
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_MI: taken = s;
            COND_PL: taken = ~s;
            COND_CS: taken = c;
            COND_CC: taken = ~c;
            COND_VS: taken = v;
            COND_VC: taken = ~v;
            COND_LT: taken = s ^ v;
            COND_GE: taken = ~(s ^ v);
            COND_LE: taken = z | (s ^ v);
            COND_GT: taken = ~(z | (s ^ v));
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b0;
            default: err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_cond_unit.sv
// flag_cond_unit: architectural S/Z/C/V flag register, outstanding
// flag-write tracker, and a request/response branch-condition port that
// never answers while a flag write is still in flight.
//   clk, rst_n                  clock, synchronous active-low reset
//   pend_issue                  a flag-writing op was issued
//   alu_valid, alu_flag_we      flag-writing result retires this cycle
//   alu_s/z/c/v                 incoming flags
//   cond_req/cond_code/cond_ready   query request handshake
//   cond_valid/cond_taken/cond_err/cond_ack   query response handshake
//   flags, pend_cnt, pend_ovf, pend_unf   status
// Optional feature macro: FLAG_FWD_EN forwards the final retiring flags
// straight into evaluation, saving one cycle of query latency.
module flag_cond_unit
    import alu_pkg::*;
#(
    parameter int PEND_MAX = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pend_issue,
    input  logic       alu_valid,
    input  logic       alu_flag_we,
    input  logic       alu_s,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       cond_req,
    input  logic [3:0] cond_code,
    output logic       cond_ready,
    output logic       cond_valid,
    output logic       cond_taken,
    output logic       cond_err,
    input  logic       cond_ack,
    output logic [3:0] flags,
    output logic [1:0] pend_cnt,
    output logic       pend_ovf,
    output logic       pend_unf
);

    localparam logic [1:0] PEND_TOP = 2'(PEND_MAX);

    cond_state_t state;
    logic [3:0]  code_q;
    logic        retire;
    logic [3:0]  alu_flags;
    logic        fwd;
    logic        pend_clear;
    logic [3:0]  ev_flags;
    logic [3:0]  ev_code;
    logic        ev_taken;
    logic        ev_err;

    assign retire    = alu_valid & alu_flag_we;
    assign alu_flags = {alu_s, alu_z, alu_c, alu_v};

`ifdef FLAG_FWD_EN
    // Final retire: the last outstanding write lands now and no new one
    // is issued alongside it, so the incoming flags are the answer.
    assign fwd = retire & ~pend_issue & (pend_cnt == 2'd1);
`else
    assign fwd = 1'b0;
`endif

    assign pend_clear = (pend_cnt == 2'd0) | fwd;
    assign ev_flags   = fwd ? alu_flags : flags;
    // In IDLE the request is being accepted this cycle, so the live code
    // is used; afterwards only the latched copy is valid.
    assign ev_code    = (state == ST_IDLE) ? cond_code : code_q;

    cond_eval u_eval (
        .flags     (ev_flags),
        .cond_code (ev_code),
        .taken     (ev_taken),
        .err       (ev_err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)      flags <= 4'd0;
        else if (retire) flags <= alu_flags;
    end

    // Issue and retire together cancel; saturation sets sticky errors.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_cnt <= 2'd0;
            pend_ovf <= 1'b0;
            pend_unf <= 1'b0;
        end else begin
            case ({pend_issue, retire})
                2'b10: begin
                    if (pend_cnt == PEND_TOP) pend_ovf <= 1'b1;
                    else                      pend_cnt <= pend_cnt + 2'd1;
                end
                2'b01: begin
                    if (pend_cnt == 2'd0) pend_unf <= 1'b1;
                    else                  pend_cnt <= pend_cnt - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            code_q     <= 4'd0;
            cond_ready <= 1'b1;
            cond_valid <= 1'b0;
            cond_taken <= 1'b0;
            cond_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cond_req) begin
                        code_q     <= cond_code;
                        cond_ready <= 1'b0;
                        if (pend_clear) begin
                            cond_taken <= ev_taken;
                            cond_err   <= ev_err;
                            cond_valid <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            state      <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (pend_clear) begin
                        cond_taken <= ev_taken;
                        cond_err   <= ev_err;
                        cond_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (cond_ack) begin
                        cond_valid <= 1'b0;
                        cond_ready <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    cond_valid <= 1'b0;
                    cond_ready <= 1'b1;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flag_cond_unit.sv
// tb_flag_cond_unit: directed self-checking bench for flag_cond_unit.
// Honors FLAG_FWD_EN for the latency-dependent expectations.
module tb_flag_cond_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pend_issue, alu_valid, alu_flag_we;
    logic       alu_s, alu_z, alu_c, alu_v;
    logic       cond_req, cond_ack;
    logic [3:0] cond_code;
    logic       cond_ready, cond_valid, cond_taken, cond_err;
    logic [3:0] flags;
    logic [1:0] pend_cnt;
    logic       pend_ovf, pend_unf;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    flag_cond_unit #(.PEND_MAX(3)) dut (
        .clk(clk), .rst_n(rst_n), .pend_issue(pend_issue),
        .alu_valid(alu_valid), .alu_flag_we(alu_flag_we),
        .alu_s(alu_s), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .cond_req(cond_req), .cond_code(cond_code), .cond_ready(cond_ready),
        .cond_valid(cond_valid), .cond_taken(cond_taken), .cond_err(cond_err),
        .cond_ack(cond_ack), .flags(flags), .pend_cnt(pend_cnt),
        .pend_ovf(pend_ovf), .pend_unf(pend_unf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [3:0] f);
        alu_valid = 1'b1; alu_flag_we = 1'b1;
        {alu_s, alu_z, alu_c, alu_v} = f;
    endtask

    task automatic clr_in();
        pend_issue = 1'b0; alu_valid = 1'b0; alu_flag_we = 1'b0;
        {alu_s, alu_z, alu_c, alu_v} = 4'd0;
        cond_req = 1'b0; cond_ack = 1'b0; cond_code = 4'd0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_flags"}, 32'(flags), 32'h0);
        chk({tag, "_cnt"},   32'(pend_cnt), 32'h0);
        chk({tag, "_ovf"},   32'(pend_ovf), 32'h0);
        chk({tag, "_unf"},   32'(pend_unf), 32'h0);
        chk({tag, "_ready"}, 32'(cond_ready), 32'h1);
        chk({tag, "_valid"}, 32'(cond_valid), 32'h0);
        chk({tag, "_taken"}, 32'(cond_taken), 32'h0);
        chk({tag, "_err"},   32'(cond_err), 32'h0);
    endtask

    // Query with nothing pending: response visible right after accept edge.
    task automatic query(input string tag, input logic [3:0] code,
                         input logic exp_taken, input logic exp_err);
        cond_req = 1'b1; cond_code = code;
        step();
        cond_req = 1'b0;
        chk({tag, "_valid"}, 32'(cond_valid), 32'h1);
        chk({tag, "_taken"}, 32'(cond_taken), 32'(exp_taken));
        chk({tag, "_err"},   32'(cond_err),   32'(exp_err));
        cond_ack = 1'b1;
        step();
        cond_ack = 1'b0;
        chk({tag, "_ackvalid"}, 32'(cond_valid), 32'h0);
        chk({tag, "_ackready"}, 32'(cond_ready), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        clr_in();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        chk_reset_state("rst");

        // Load S=0 Z=1 C=0 V=0 through one issued op.
        pend_issue = 1'b1; step(); pend_issue = 1'b0;
        chk("cnt1", 32'(pend_cnt), 32'h1);
        set_alu(4'b0100); step(); clr_in();
        chk("flags_z", 32'(flags), 32'h4);
        chk("cnt_drained", 32'(pend_cnt), 32'h0);
        chk("unf_clean", 32'(pend_unf), 32'h0);

        query("eq", 4'd0, 1'b1, 1'b0);
        query("ne", 4'd1, 1'b0, 1'b0);
        query("le", 4'd10, 1'b1, 1'b0);
        query("gt", 4'd11, 1'b0, 1'b0);
        query("r14", 4'd14, 1'b0, 1'b1);
        query("r15", 4'd15, 1'b0, 1'b1);
        query("al", 4'd12, 1'b1, 1'b0);
        query("nv", 4'd13, 1'b0, 1'b0);

        // GE with two writes outstanding: first retire S=1,V=0 (GE false),
        // final retire S=0,V=0 (GE true).
        pend_issue = 1'b1; step(); step(); pend_issue = 1'b0;
        chk("cnt2", 32'(pend_cnt), 32'h2);
        cond_req = 1'b1; cond_code = 4'd9; step(); cond_req = 1'b0;
        chk("ge_wait_valid", 32'(cond_valid), 32'h0);
        chk("ge_wait_ready", 32'(cond_ready), 32'h0);
        set_alu(4'b1000); step(); clr_in();
        chk("ge_ret1_valid", 32'(cond_valid), 32'h0);
        set_alu(4'b0000); step(); clr_in();
`ifdef FLAG_FWD_EN
        chk("ge_m1_valid", 32'(cond_valid), 32'h1);
        chk("ge_m1_taken", 32'(cond_taken), 32'h1);
`else
        chk("ge_m1_valid", 32'(cond_valid), 32'h0);
        step();
        chk("ge_m2_valid", 32'(cond_valid), 32'h1);
        chk("ge_m2_taken", 32'(cond_taken), 32'h1);
`endif
        cond_ack = 1'b1; step(); cond_ack = 1'b0;
        chk("ge_idle", 32'(cond_ready), 32'h1);

        // Response stays stable for 5 cycles while the flags change.
        cond_req = 1'b1; cond_code = 4'd0; step(); cond_req = 1'b0;
        chk("hold_taken0", 32'(cond_taken), 32'h0);
        for (int i = 0; i < 5; i++) begin
            pend_issue = 1'b1; set_alu(4'b0100);
            step();
            chk("hold_valid", 32'(cond_valid), 32'h1);
            chk("hold_taken", 32'(cond_taken), 32'h0);
        end
        clr_in();
        chk("hold_flags", 32'(flags), 32'h4);
        chk("hold_cnt", 32'(pend_cnt), 32'h0);
        cond_ack = 1'b1; step(); cond_ack = 1'b0;
        chk("hold_ack_valid", 32'(cond_valid), 32'h0);
        chk("hold_ack_ready", 32'(cond_ready), 32'h1);

        // Issue alongside accept at count 0: query orders before the op.
        cond_req = 1'b1; cond_code = 4'd0; pend_issue = 1'b1;
        step(); clr_in();
        chk("iss_acc_valid", 32'(cond_valid), 32'h1);
        chk("iss_acc_taken", 32'(cond_taken), 32'h1);
        chk("iss_acc_cnt", 32'(pend_cnt), 32'h1);
        cond_ack = 1'b1; step(); cond_ack = 1'b0;
        set_alu(4'b0000); step(); clr_in();   // drain, flags -> 0

        // Accept coinciding with the final retire (incoming Z=1, EQ).
        pend_issue = 1'b1; step(); clr_in();
        cond_req = 1'b1; cond_code = 4'd0; set_alu(4'b0100);
        step(); clr_in();
`ifdef FLAG_FWD_EN
        chk("acc_ret_valid", 32'(cond_valid), 32'h1);
        chk("acc_ret_taken", 32'(cond_taken), 32'h1);
`else
        chk("acc_ret_wait", 32'(cond_valid), 32'h0);
        step();
        chk("acc_ret_valid", 32'(cond_valid), 32'h1);
        chk("acc_ret_taken", 32'(cond_taken), 32'h1);
`endif
        cond_ack = 1'b1; step(); cond_ack = 1'b0;

        // Saturation: 4 issues -> 3 + overflow; drain, one extra retire.
        pend_issue = 1'b1; step(); step(); step(); pend_issue = 1'b0;
        chk("sat_cnt3", 32'(pend_cnt), 32'h3);
        chk("sat_ovf0", 32'(pend_ovf), 32'h0);
        pend_issue = 1'b1; step(); pend_issue = 1'b0;
        chk("sat_cnt", 32'(pend_cnt), 32'h3);
        chk("sat_ovf", 32'(pend_ovf), 32'h1);
        set_alu(4'b0010); step(); step(); step(); clr_in();
        chk("drain_cnt", 32'(pend_cnt), 32'h0);
        chk("drain_unf0", 32'(pend_unf), 32'h0);
        set_alu(4'b0001); step(); clr_in();
        chk("unf_cnt", 32'(pend_cnt), 32'h0);
        chk("unf_set", 32'(pend_unf), 32'h1);
        chk("unf_flags", 32'(flags), 32'h1);
        chk("ovf_sticky", 32'(pend_ovf), 32'h1);

        // Reset while a query waits.
        pend_issue = 1'b1; step(); clr_in();
        cond_req = 1'b1; cond_code = 4'd12; step(); cond_req = 1'b0;
        chk("rw_ready", 32'(cond_ready), 32'h0);
        chk("rw_valid", 32'(cond_valid), 32'h0);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk_reset_state("rw");
        step(); step();
        chk("rw_post_valid", 32'(cond_valid), 32'h0);
        chk("rw_post_ready", 32'(cond_ready), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
